// File: rtl/cb_doutb_demap_pkg.sv
// Shared CB select and read-side FSM encodings, common to the CB write-side mapper.
// Also provides the per-mode read count used by the read-back sequencer.
package cb_doutb_demap_pkg;

  typedef enum logic [1:0] {
    CB_SEL_IDLE   = 2'b00,
    CB_SEL_RSVD   = 2'b01,
    CB_SEL_XYXITA = 2'b10,
    CB_SEL_LXLY   = 2'b11
  } cb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } cb_state_e;

  localparam int CB_STEP_W = 2;

  // XYXITA reads three words, LXLY reads two; returns the index of the final step.
  function automatic logic [CB_STEP_W-1:0] cb_last_step(input cb_sel_e sel);
    return (sel == CB_SEL_XYXITA) ? CB_STEP_W'(2) : CB_STEP_W'(1);
  endfunction

endpackage

// File: rtl/cb_doutb_demap_rd_tag_pipe.sv
// Shift pipe that delays a read tag by RD_LAT cycles so it lines up with CB port-B data.
// pend flags tags that have not yet reached the output stage.
module CB_rd_tag_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output logic             pend
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [RD_LAT];
  logic [TAG_W-1:0]  tag_d [RD_LAT];

  always_comb begin
    vld_d[0] = in_vld;
    tag_d[0] = in_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // The output stage is excluded: it is consumed on the same edge the drain completes.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pend = pend | vld_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_tag = tag_q[RD_LAT-1];

endmodule

// File: rtl/cb_doutb_demap.sv
// Reads 2 or 3 consecutive CB words on port B and extracts one lane per word into the
// recovered state registers; done pulses N+RD_LAT+1 cycles after the start edge.
module cb_doutb_demap
  import cb_doutb_demap_pkg::*;
#(
  parameter int L               = 4,
  parameter int RSA_DW          = 32,
  parameter int CB_AW           = 10,
  parameter int RD_LAT          = 2,
  parameter int CB_DOUTB_SEL_DW = 2
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic [CB_DOUTB_SEL_DW-1:0] CB_doutb_sel,
  input  logic                       start,
  input  logic [CB_AW-1:0]           base_addr,
  output logic                       CB_enb,
  output logic [CB_AW-1:0]           CB_addrb,
  input  logic [L*RSA_DW-1:0]        CB_doutb,
  output logic signed [RSA_DW-1:0]   x_hat,
  output logic signed [RSA_DW-1:0]   y_hat,
  output logic signed [RSA_DW-1:0]   xita_hat,
  output logic signed [RSA_DW-1:0]   lkx,
  output logic signed [RSA_DW-1:0]   lky,
  output logic                       busy,
  output logic                       done
);

  cb_state_e               state_q, state_d;
  cb_sel_e                 sel_q, sel_d;
  logic [CB_STEP_W-1:0]    step_q, step_d;
  logic [CB_AW-1:0]        addr_q, addr_d;
  logic signed [RSA_DW-1:0] x_q, x_d, y_q, y_d, xita_q, xita_d, lkx_q, lkx_d, lky_q, lky_d;

  logic                    issue;
  logic                    start_ok;
  logic                    tag_vld;
  logic [CB_STEP_W-1:0]    tag_step;
  logic                    tag_pend;
  logic signed [RSA_DW-1:0] lane0, lane1, lane2;
  logic                    unused_doutb;

  assign lane0 = $signed(CB_doutb[0*RSA_DW +: RSA_DW]);
  assign lane1 = $signed(CB_doutb[1*RSA_DW +: RSA_DW]);
  assign lane2 = $signed(CB_doutb[2*RSA_DW +: RSA_DW]);
  assign unused_doutb = ^CB_doutb;

  assign start_ok = start &&
                    ((CB_doutb_sel == CB_DOUTB_SEL_DW'(CB_SEL_XYXITA)) ||
                     (CB_doutb_sel == CB_DOUTB_SEL_DW'(CB_SEL_LXLY)));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = step_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          sel_d   = cb_sel_e'(CB_doutb_sel[1:0]);
          addr_d  = base_addr;
          step_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (step_q == cb_last_step(sel_q)) begin
          state_d = ST_DRAIN;
        end else begin
          step_d = step_q + CB_STEP_W'(1);
          addr_d = addr_q + CB_AW'(1);
        end
      end
      ST_DRAIN: begin
        if (!tag_pend) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the lane owned by the returning step is taken; every other output holds.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xita_d = xita_q;
    lkx_d  = lkx_q;
    lky_d  = lky_q;
    if (tag_vld) begin
      case (sel_q)
        CB_SEL_XYXITA: begin
          case (tag_step)
            2'd0:    x_d    = lane0;
            2'd1:    y_d    = lane1;
            2'd2:    xita_d = lane2;
            default: ;
          endcase
        end
        CB_SEL_LXLY: begin
          case (tag_step)
            2'd0:    lkx_d = lane0;
            2'd1:    lky_d = lane1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= CB_SEL_IDLE;
      step_q  <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xita_q  <= '0;
      lkx_q   <= '0;
      lky_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xita_q  <= xita_d;
      lkx_q   <= lkx_d;
      lky_q   <= lky_d;
    end
  end

  CB_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (CB_STEP_W)
  ) u_tag_pipe (
    .clk     (clk),
    .sys_rst (sys_rst),
    .in_vld  (issue),
    .in_tag  (step_q),
    .out_vld (tag_vld),
    .out_tag (tag_step),
    .pend    (tag_pend)
  );

  assign CB_enb   = (state_q == ST_ISSUE);
  assign CB_addrb = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign x_hat    = x_q;
  assign y_hat    = y_q;
  assign xita_hat = xita_q;
  assign lkx      = lkx_q;
  assign lky      = lky_q;

endmodule

// File: tb/tb_cb_doutb_demap.sv
// Bench for cb_doutb_demap: CB port-B memory model with RD_LAT pipeline, scoreboard of
// expected data outputs popped on every done pulse, and per-scenario timing checks.
module tb_cb_doutb_demap;

  localparam int L  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int SW = 2;
  localparam logic [L*DW-1:0] FILL = {L{32'hDEADBEEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             sys_rst = 1'b1;
  logic             start   = 1'b0;
  logic [SW-1:0]    cb_sel  = 2'b00;
  logic [AW-1:0]    base    = '0;
  logic             CB_enb;
  logic [AW-1:0]    CB_addrb;
  logic [L*DW-1:0]  CB_doutb;
  logic signed [DW-1:0] x_hat, y_hat, xita_hat, lkx, lky;
  logic             busy, done;

  cb_doutb_demap #(
    .L(L), .RSA_DW(DW), .CB_AW(AW), .RD_LAT(RL), .CB_DOUTB_SEL_DW(SW)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .CB_doutb_sel(cb_sel), .start(start),
    .base_addr(base), .CB_enb(CB_enb), .CB_addrb(CB_addrb), .CB_doutb(CB_doutb),
    .x_hat(x_hat), .y_hat(y_hat), .xita_hat(xita_hat), .lkx(lkx), .lky(lky),
    .busy(busy), .done(done)
  );

  // CB port-B model: unread cycles return filler so a mistimed capture is visible.
  logic [L*DW-1:0] mem [0:(1<<AW)-1];
  logic [L*DW-1:0] rd_pipe [RL];
  initial for (int i = 0; i < RL; i++) rd_pipe[i] = FILL;
  always @(posedge clk) begin
    rd_pipe[0] <= (CB_enb === 1'b1) ? mem[CB_addrb] : FILL;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign CB_doutb = rd_pipe[RL-1];

  typedef struct {
    logic signed [DW-1:0] x, y, xita, lkx, lky;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  logic signed [DW-1:0] cur_x = 0, cur_y = 0, cur_xita = 0, cur_lkx = 0, cur_lky = 0;
  int total = 0;
  int bad   = 0;

  logic          obs_enb  [1:24];
  logic          obs_busy [1:24];
  logic          obs_done [1:24];
  logic          obs_zero [1:24];
  logic [AW-1:0] obs_addr [1:24];

  function automatic logic [L*DW-1:0] word(input int lane, input logic signed [DW-1:0] v);
    logic [L*DW-1:0] w;
    w = FILL;
    w[lane*DW +: DW] = v;
    return w;
  endfunction

  function automatic void push_exp();
    exp_t t;
    t.x = cur_x; t.y = cur_y; t.xita = cur_xita; t.lkx = cur_lkx; t.lky = cur_lky;
    sbq.push_back(t);
  endfunction

  function automatic logic [23:0] obs_mask(input int kind, input int np);
    logic [23:0] m;
    m = '0;
    for (int p = 1; p <= np; p++) begin
      case (kind)
        0:       m[p-1] = obs_enb[p];
        1:       m[p-1] = obs_busy[p];
        default: m[p-1] = obs_done[p];
      endcase
    end
    return m;
  endfunction

  function automatic logic [23:0] win_mask(input int f1, input int l1, input int f2, input int l2);
    logic [23:0] m;
    m = '0;
    for (int p = 1; p <= 24; p++)
      if ((p >= f1 && p <= l1) || (p >= f2 && p <= l2)) m[p-1] = 1'b1;
    return m;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: done=1 at %0t, required no done (nothing pending)", $time);
      end else begin
        e = sbq.pop_front();
        if ({x_hat, y_hat, xita_hat, lkx, lky} !== {e.x, e.y, e.xita, e.lkx, e.lky}) begin
          bad++;
          $display("FAIL sb_data: got x=%0d y=%0d xita=%0d lkx=%0d lky=%0d, required x=%0d y=%0d xita=%0d lkx=%0d lky=%0d",
                   x_hat, y_hat, xita_hat, lkx, lky, e.x, e.y, e.xita, e.lkx, e.lky);
        end
      end
    end
  end

  // Called just after a negedge: issues start, then records np periods after the start edge.
  task automatic observe(input logic [1:0] s, input logic [AW-1:0] b, input int np,
                         input int rs_p, input logic [1:0] rs_sel, input logic [AW-1:0] rs_base,
                         input int rst_p);
    cb_sel = s;
    base   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cb_sel = 2'b01;
    base   = ~b;
    for (int p = 1; p <= np; p++) begin
      @(negedge clk);
      obs_enb[p]  = CB_enb;
      obs_busy[p] = busy;
      obs_done[p] = done;
      obs_addr[p] = CB_addrb;
      obs_zero[p] = (CB_enb === 1'b0) && (CB_addrb === '0) && (busy === 1'b0) &&
                    (done === 1'b0) && (x_hat === '0) && (y_hat === '0) &&
                    (xita_hat === '0) && (lkx === '0) && (lky === '0);
      if (p == rs_p) begin
        start  = 1'b1;
        cb_sel = rs_sel;
        base   = rs_base;
      end else begin
        start  = 1'b0;
      end
      sys_rst = (p == rst_p);
    end
    start   = 1'b0;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({CB_enb, busy, done} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: enb/busy/done=%b required 000", {CB_enb, busy, done});
    end
    total++;
    if (CB_addrb !== '0) begin
      bad++; $display("FAIL reset_addr: CB_addrb=%h required 000", CB_addrb);
    end
    total++;
    if ({x_hat, y_hat, xita_hat, lkx, lky} !== '0) begin
      bad++; $display("FAIL reset_data: x=%0d y=%0d xita=%0d lkx=%0d lky=%0d required all 0",
                      x_hat, y_hat, xita_hat, lkx, lky);
    end
    sys_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_xyxita();
    mem[10'h010] = word(0, 100);
    mem[10'h011] = word(1, -200);
    mem[10'h012] = word(2, 300);
    cur_x = 100; cur_y = -200; cur_xita = 300;
    push_exp();
    observe(2'b10, 10'h010, 12, 0, 2'b00, '0, 0);
    total++;
    if (obs_mask(0, 12) !== win_mask(1, 3, 0, -1)) begin
      bad++; $display("FAIL xy_enb: periods=%h required %h", obs_mask(0, 12), win_mask(1, 3, 0, -1));
    end
    total++;
    if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== {10'h010, 10'h011, 10'h012}) begin
      bad++; $display("FAIL xy_addr: got %h %h %h required 010 011 012", obs_addr[1], obs_addr[2], obs_addr[3]);
    end
    total++;
    if (obs_mask(2, 12) !== win_mask(6, 6, 0, -1)) begin
      bad++; $display("FAIL xy_done: periods=%h required %h", obs_mask(2, 12), win_mask(6, 6, 0, -1));
    end
    total++;
    if (obs_mask(1, 12) !== win_mask(1, 6, 0, -1)) begin
      bad++; $display("FAIL xy_busy: periods=%h required %h", obs_mask(1, 12), win_mask(1, 6, 0, -1));
    end
    total++;
    if (obs_addr[12] !== 10'h012) begin
      bad++; $display("FAIL xy_addr_hold: CB_addrb=%h required 012", obs_addr[12]);
    end
  endtask

  task automatic test_lxly_wrap();
    mem[10'h3FF] = word(0, -7);
    mem[10'h000] = word(1, 12345);
    cur_lkx = -7; cur_lky = 12345;
    push_exp();
    observe(2'b11, 10'h3FF, 10, 0, 2'b00, '0, 0);
    total++;
    if (obs_mask(0, 10) !== win_mask(1, 2, 0, -1)) begin
      bad++; $display("FAIL lx_enb: periods=%h required %h", obs_mask(0, 10), win_mask(1, 2, 0, -1));
    end
    total++;
    if ({obs_addr[1], obs_addr[2]} !== {10'h3FF, 10'h000}) begin
      bad++; $display("FAIL lx_addr_wrap: got %h %h required 3ff 000", obs_addr[1], obs_addr[2]);
    end
    total++;
    if (obs_mask(2, 10) !== win_mask(5, 5, 0, -1)) begin
      bad++; $display("FAIL lx_done: periods=%h required %h", obs_mask(2, 10), win_mask(5, 5, 0, -1));
    end
    total++;
    if (obs_mask(1, 10) !== win_mask(1, 5, 0, -1)) begin
      bad++; $display("FAIL lx_busy: periods=%h required %h", obs_mask(1, 10), win_mask(1, 5, 0, -1));
    end
  endtask

  task automatic test_bad_sel();
    logic [1:0] sels [2];
    sels[0] = 2'b01;
    sels[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      observe(sels[i], 10'h010, 8, 0, 2'b00, '0, 0);
      total++;
      if ((obs_mask(0, 8) | obs_mask(1, 8) | obs_mask(2, 8)) !== '0) begin
        bad++; $display("FAIL bad_sel_%b: enb=%h busy=%h done=%h required all 0", sels[i],
                        obs_mask(0, 8), obs_mask(1, 8), obs_mask(2, 8));
      end
    end
  endtask

  task automatic test_restart_busy();
    mem[10'h020] = word(0, 7);
    mem[10'h021] = word(1, -8);
    mem[10'h022] = word(2, 9);
    cur_x = 7; cur_y = -8; cur_xita = 9;
    push_exp();
    observe(2'b10, 10'h020, 16, 2, 2'b11, 10'h3FF, 0);
    total++;
    if (obs_mask(0, 16) !== win_mask(1, 3, 0, -1)) begin
      bad++; $display("FAIL restart_enb: periods=%h required %h", obs_mask(0, 16), win_mask(1, 3, 0, -1));
    end
    total++;
    if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== {10'h020, 10'h021, 10'h022}) begin
      bad++; $display("FAIL restart_addr: got %h %h %h required 020 021 022", obs_addr[1], obs_addr[2], obs_addr[3]);
    end
    total++;
    if (obs_mask(2, 16) !== win_mask(6, 6, 0, -1)) begin
      bad++; $display("FAIL restart_done: periods=%h required %h", obs_mask(2, 16), win_mask(6, 6, 0, -1));
    end
  endtask

  task automatic test_done_start();
    mem[10'h040] = word(0, 55);
    mem[10'h041] = word(1, -66);
    cur_lkx = 55; cur_lky = -66;
    push_exp();
    observe(2'b11, 10'h040, 12, 5, 2'b10, 10'h010, 0);
    total++;
    if (obs_mask(0, 12) !== win_mask(1, 2, 0, -1)) begin
      bad++; $display("FAIL done_start_enb: periods=%h required %h", obs_mask(0, 12), win_mask(1, 2, 0, -1));
    end
    total++;
    if (obs_mask(2, 12) !== win_mask(5, 5, 0, -1)) begin
      bad++; $display("FAIL done_start_done: periods=%h required %h", obs_mask(2, 12), win_mask(5, 5, 0, -1));
    end
  endtask

  task automatic test_back_to_back();
    mem[10'h050] = word(0, -1);
    mem[10'h051] = word(1, 1);
    mem[10'h060] = word(0, 2000);
    mem[10'h061] = word(1, -3000);
    cur_lkx = -1; cur_lky = 1;
    push_exp();
    cur_lkx = 2000; cur_lky = -3000;
    push_exp();
    observe(2'b11, 10'h050, 14, 6, 2'b11, 10'h060, 0);
    total++;
    if (obs_mask(0, 14) !== win_mask(1, 2, 7, 8)) begin
      bad++; $display("FAIL b2b_enb: periods=%h required %h", obs_mask(0, 14), win_mask(1, 2, 7, 8));
    end
    total++;
    if ({obs_addr[1], obs_addr[2], obs_addr[7], obs_addr[8]} !== {10'h050, 10'h051, 10'h060, 10'h061}) begin
      bad++; $display("FAIL b2b_addr: got %h %h %h %h required 050 051 060 061",
                      obs_addr[1], obs_addr[2], obs_addr[7], obs_addr[8]);
    end
    total++;
    if (obs_mask(1, 14) !== win_mask(1, 5, 7, 11)) begin
      bad++; $display("FAIL b2b_busy: periods=%h required %h", obs_mask(1, 14), win_mask(1, 5, 7, 11));
    end
    total++;
    if (obs_mask(2, 14) !== win_mask(5, 5, 11, 11)) begin
      bad++; $display("FAIL b2b_done: periods=%h required %h", obs_mask(2, 14), win_mask(5, 5, 11, 11));
    end
  endtask

  task automatic test_reset_mid();
    logic all_zero;
    mem[10'h030] = word(0, 11);
    mem[10'h031] = word(1, 22);
    mem[10'h032] = word(2, 33);
    cur_x = 0; cur_y = 0; cur_xita = 0; cur_lkx = 0; cur_lky = 0;
    observe(2'b10, 10'h030, 12, 0, 2'b00, '0, 3);
    total++;
    if (obs_zero[4] !== 1'b1) begin
      bad++; $display("FAIL rst_mid_clear: all-zero after reset=%b required 1", obs_zero[4]);
    end
    all_zero = 1'b1;
    for (int p = 4; p <= 12; p++) all_zero = all_zero & obs_zero[p];
    total++;
    if (all_zero !== 1'b1) begin
      bad++; $display("FAIL rst_mid_inflight: outputs stayed zero=%b required 1 (x=%0d y=%0d)",
                      all_zero, x_hat, y_hat);
    end
    total++;
    if (obs_mask(0, 12) !== win_mask(1, 3, 0, -1)) begin
      bad++; $display("FAIL rst_mid_enb: periods=%h required %h", obs_mask(0, 12), win_mask(1, 3, 0, -1));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = FILL;
    test_reset();
    test_xyxita();
    test_lxly_wrap();
    test_bad_sel();
    test_restart_busy();
    test_done_start();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL sb_pending: %0d results never produced, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cb_doutb_demap.md
CB_DOUTB_DEMAP -- requirements
Module: CB_doutb_demap

Interface
REQ-001 SHALL have parameter L, default 4, number of RSA_DW-wide lanes in one CB word.
REQ-002 SHALL have parameter RSA_DW, default 32, width of one signed state element.
REQ-003 SHALL have parameter CB_AW, default 10, CB port-B address width.
REQ-004 SHALL have parameter RD_LAT, default 2, CB port-B read latency in cycles (range 1..4).
REQ-005 SHALL have parameter CB_DOUTB_SEL_DW, default 2, select width.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 sys_rst  in  1  synchronous, active-high reset.
REQ-009 CB_doutb_sel  in  CB_DOUTB_SEL_DW  mode: 2'b00 IDLE, 2'b10 XYXITA, 2'b11 LXLY; 2'b01 reserved.
REQ-010 start  in  1  one-cycle request to begin a read-back.
REQ-011 base_addr  in  CB_AW  CB address of the first word to read.
REQ-012 CB_enb  out  1  CB port-B read enable.
REQ-013 CB_addrb  out  CB_AW  CB port-B read address.
REQ-014 CB_doutb  in  L*RSA_DW  CB port-B read data.
REQ-015 x_hat, y_hat, xita_hat, lkx, lky  out  RSA_DW each, signed  recovered state elements.
REQ-016 busy  out  1  high from the first issue cycle through the done cycle.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-019 In IDLE, start=1 with sel XYXITA or LXLY SHALL latch sel and base_addr and go to ISSUE; any other sel SHALL ignore start.
REQ-020 Read count N SHALL be 3 for XYXITA and 2 for LXLY.
REQ-021 In ISSUE, step k=0..N-1 SHALL drive CB_enb=1, CB_addrb=base_addr+k (modulo 2^CB_AW), one step per cycle; after step N-1 go to DRAIN.
REQ-022 Each issued read SHALL push a tag (valid, step k) into an RD_LAT-deep shift pipe; a tag emerging RD_LAT cycles later SHALL capture CB_doutb.
REQ-023 XYXITA capture: step0 lane0 -> x_hat, step1 lane1 -> y_hat, step2 lane2 -> xita_hat.
REQ-024 LXLY capture: step0 lane0 -> lkx, step1 lane1 -> lky.
REQ-025 Captures SHALL ignore all non-selected lanes; outputs not targeted by the active mode SHALL hold.
REQ-026 DRAIN SHALL wait until the tag pipe is empty, then go to DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-027 With start sampled at edge t0: CB_enb high in cycles t0+1..t0+N; done in cycle t0+N+RD_LAT+1; busy high t0+1..t0+N+RD_LAT+1.
REQ-028 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored; back-to-back requests need start in IDLE.
REQ-029 Changes of CB_doutb_sel or base_addr after the start edge SHALL not affect the running operation.
REQ-030 CB_enb SHALL be 0 and CB_addrb SHALL hold its last value outside ISSUE.
REQ-031 Data outputs SHALL hold their last captured value indefinitely.

Reset
REQ-032 sys_rst SHALL force IDLE, clear tag pipe, and zero CB_enb, CB_addrb, busy, done, and all five data outputs.
REQ-033 sys_rst mid-operation SHALL abort; in-flight read data arriving after reset SHALL not be captured.

Structure
REQ-034 Sel encodings (IDLE, XYXITA, LXLY) and FSM state encodings SHALL live in the shared package, common with the CB write-side mapper.
REQ-035 The tag pipe SHALL be a sub-module CB_rd_tag_pipe (parameters RD_LAT, tag width).

Verification
REQ-036 XYXITA, base_addr=0x010, RD_LAT=2, CB returns words with lanes 0/1/2 = 100/-200/300 at 0x010/0x011/0x012 -> x_hat=100, y_hat=-200, xita_hat=300, done at t0+6, lkx/lky unchanged.
REQ-037 LXLY, base_addr=0x3FF, CB_AW=10 -> CB_addrb 0x3FF then 0x000; lkx, lky from lane0/lane1; done at t0+5.
REQ-038 start with sel=2'b01 or 2'b00 -> no CB_enb, busy stays 0, no done.
REQ-039 start re-asserted at t0+2 during XYXITA -> ignored, exactly 3 reads, one done.
REQ-040 sys_rst at t0+3 in XYXITA -> all outputs 0 next cycle, no capture from in-flight reads, no done.
REQ-041 Non-selected lanes driven 0xDEADBEEF -> never appear on any data output.
